// File: rtl/cpu_pkg.sv
// Shared CPU definitions: interrupt sequencer state encoding and defaults.
//   VEC_ADDR_DEF - memory address holding the ISR start address
//   FLAG_W_DEF   - condition-flag width (Z,N,C,V)
//   seq_state_t  - interrupt entry sequencer states
package cpu_pkg;

    localparam logic [7:0]  VEC_ADDR_DEF = 8'h01;
    localparam int unsigned FLAG_W_DEF   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_PUSH_PC,
        ST_PUSH_FLG,
        ST_VEC_RD,
        ST_VEC_WAIT,
        ST_JUMP,
        ST_SERVICE
    } seq_state_t;

endpackage

// File: rtl/int_pend_latch.sv
// Pending-interrupt latch.
//   clk     - rising-edge clock
//   rstn    - synchronous active-low reset
//   set     - raw interrupt request; sets pending on any edge it is high
//   clear   - clears pending (taken when the sequencer commits to the push)
//   pending - one outstanding interrupt; further sets while high do not queue
module int_pend_latch (
    input  logic clk,
    input  logic rstn,
    input  logic set,
    input  logic clear,
    output logic pending
);

    // Clear wins over a coincident set so a request already being taken
    // is not counted twice.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pending <= 1'b0;
        end else if (clear) begin
            pending <= 1'b0;
        end else if (set) begin
            pending <= 1'b1;
        end
    end

endmodule

// File: rtl/int_sequencer.sv
// Interrupt entry sequencer: drains the pipeline, pushes PC and flags onto
// the R3 stack, fetches the ISR vector, loads the PC and waits for RTI.
//   clk, rstn           - clock, synchronous active-low reset
//   int_sig, gie        - interrupt request, global interrupt enable
//   pipe_empty          - no instruction in flight past fetch
//   pc_resume, flags_in - return address and flags to save
//   sp_in               - current stack pointer (R3)
//   rti_done            - RTI retired (only honoured in service)
//   mem_gnt, mem_rdata  - memory grant, read data (cycle after granted read)
//   mem_req/we/addr/wdata - memory access request
//   stall_fetch, flush  - fetch freeze, one-cycle front-end flush
//   pc_ld, pc_ld_val    - PC load strobe and value
//   sp_wr_en, sp_wr_val - R3 update strobe and value
//   in_service          - ISR active, blocks further entry
module int_sequencer
    import cpu_pkg::*;
#(
    parameter logic [7:0]  VEC_ADDR = VEC_ADDR_DEF,
    parameter int unsigned FLAG_W   = FLAG_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              int_sig,
    input  logic              gie,
    input  logic              pipe_empty,
    input  logic [7:0]        pc_resume,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic [7:0]        sp_in,
    input  logic              rti_done,
    input  logic              mem_gnt,
    input  logic [7:0]        mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [7:0]        mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              stall_fetch,
    output logic              flush,
    output logic              pc_ld,
    output logic [7:0]        pc_ld_val,
    output logic              sp_wr_en,
    output logic [7:0]        sp_wr_val,
    output logic              in_service
);

    seq_state_t        state, state_nxt;
    logic [7:0]        sp_q, pc_q, vec_q;
    logic [FLAG_W-1:0] flg_q;
    logic [7:0]        flg_ext;
    logic              pending;
    logic              take_snapshot;

    // Snapshot and pending clear happen on the DRAIN -> PUSH_PC transition.
    assign take_snapshot = (state == ST_DRAIN) && pipe_empty;

    int_pend_latch u_pend (
        .clk     (clk),
        .rstn    (rstn),
        .set     (int_sig),
        .clear   (take_snapshot),
        .pending (pending)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_IDLE;
            sp_q  <= '0;
            pc_q  <= '0;
            flg_q <= '0;
            vec_q <= '0;
        end else begin
            state <= state_nxt;
            if (take_snapshot) begin
                sp_q  <= sp_in;
                pc_q  <= pc_resume;
                flg_q <= flags_in;
            end
            if (state == ST_VEC_WAIT) begin
                vec_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        flg_ext                = '0;
        flg_ext[FLAG_W-1:0]    = flg_q;
    end

    // Outputs depend on state and held registers only, so address/data stay
    // stable for as long as a request waits for its grant.
    always_comb begin
        state_nxt   = state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        stall_fetch = 1'b0;
        flush       = 1'b0;
        pc_ld       = 1'b0;
        pc_ld_val   = '0;
        sp_wr_en    = 1'b0;
        sp_wr_val   = '0;
        in_service  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pending && gie) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                stall_fetch = 1'b1;
                if (pipe_empty) state_nxt = ST_PUSH_PC;
            end
            ST_PUSH_PC: begin
                stall_fetch = 1'b1;
                mem_req     = 1'b1;
                mem_we      = 1'b1;
                mem_addr    = sp_q;
                mem_wdata   = pc_q;
                if (mem_gnt) state_nxt = ST_PUSH_FLG;
            end
            ST_PUSH_FLG: begin
                stall_fetch = 1'b1;
                mem_req     = 1'b1;
                mem_we      = 1'b1;
                mem_addr    = sp_q - 8'd1;
                mem_wdata   = flg_ext;
                if (mem_gnt) state_nxt = ST_VEC_RD;
            end
            ST_VEC_RD: begin
                stall_fetch = 1'b1;
                mem_req     = 1'b1;
                mem_addr    = VEC_ADDR;
                if (mem_gnt) state_nxt = ST_VEC_WAIT;
            end
            ST_VEC_WAIT: begin
                stall_fetch = 1'b1;
                state_nxt   = ST_JUMP;
            end
            ST_JUMP: begin
                stall_fetch = 1'b1;
                flush       = 1'b1;
                pc_ld       = 1'b1;
                pc_ld_val   = vec_q;
                sp_wr_en    = 1'b1;
                sp_wr_val   = sp_q - 8'd2;
                state_nxt   = ST_SERVICE;
            end
            ST_SERVICE: begin
                in_service = 1'b1;
                if (rti_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_int_sequencer.sv
// Self-checking bench for int_sequencer. A behavioural memory and an entry
// model (latency arithmetic, modulo-256 stack math, expected push list)
// predict every observed value.
module tb_int_sequencer;

    localparam logic [7:0] VEC = 8'h01;

    logic       clk = 1'b0;
    logic       rstn;
    logic       int_sig, gie, pipe_empty, rti_done, mem_gnt;
    logic [7:0] pc_resume, sp_in, mem_rdata;
    logic [3:0] flags_in;
    logic       mem_req, mem_we, stall_fetch, flush, pc_ld, sp_wr_en, in_service;
    logic [7:0] mem_addr, mem_wdata, pc_ld_val, sp_wr_val;

    int_sequencer #(.VEC_ADDR(VEC), .FLAG_W(4)) dut (
        .clk(clk), .rstn(rstn), .int_sig(int_sig), .gie(gie),
        .pipe_empty(pipe_empty), .pc_resume(pc_resume), .flags_in(flags_in),
        .sp_in(sp_in), .rti_done(rti_done), .mem_gnt(mem_gnt),
        .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .stall_fetch(stall_fetch),
        .flush(flush), .pc_ld(pc_ld), .pc_ld_val(pc_ld_val),
        .sp_wr_en(sp_wr_en), .sp_wr_val(sp_wr_val), .in_service(in_service)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] mem [256];
    int         hold_left = 0;
    bit         gnt_block = 0;
    int         drain_start = -1000;
    int         drain_len = 0;
    bit         prev_wait = 0;
    logic [7:0] p_addr, p_wdata;
    logic       p_we;
    logic [7:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    bit         rd_next = 0;
    logic [7:0] rd_addr;

    // One clock cycle: choose grant / pipe_empty, observe the bus, advance.
    task automatic tick();
        bit in_drain;
        in_drain = (cyc >= drain_start) && (cyc < drain_start + drain_len);
        pipe_empty = !in_drain;
        if (gnt_block) mem_gnt = 1'b0;
        else if (mem_req && hold_left > 0) begin
            mem_gnt = 1'b0;
            hold_left--;
        end else mem_gnt = 1'b1;

        if (in_drain) begin
            checks++;
            if (stall_fetch !== 1'b1 || mem_req !== 1'b0)
                $display("FAIL drain_hold: stall=%b req=%b expected stall=1 req=0 (cyc %0d)",
                         stall_fetch, mem_req, cyc);
            if (stall_fetch !== 1'b1 || mem_req !== 1'b0) errors++;
        end
        if (prev_wait) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== p_addr || mem_wdata !== p_wdata || mem_we !== p_we) begin
                errors++;
                $display("FAIL bus_stable: req=%b addr=%h wdata=%h we=%b expected req=1 addr=%h wdata=%h we=%b",
                         mem_req, mem_addr, mem_wdata, mem_we, p_addr, p_wdata, p_we);
            end
        end
        prev_wait = mem_req && !mem_gnt && rstn;
        p_addr = mem_addr; p_wdata = mem_wdata; p_we = mem_we;

        if (mem_req && mem_gnt && rstn) begin
            if (mem_we) begin
                mem[mem_addr] = mem_wdata;
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wdata);
            end else begin
                rd_next = 1;
                rd_addr = mem_addr;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        if (rd_next) mem_rdata = mem[rd_addr];
        else mem_rdata = 8'($urandom);
        rd_next = 0;
    endtask

    // One interrupt entry. Trigger cycle c is either the int_sig pulse
    // (pulse=1) or the rti_done that releases an already pending request.
    task automatic do_entry(input logic [7:0] sp, input logic [7:0] pc, input logic [3:0] flg,
                            input logic [7:0] vec, input int hold, input int drain,
                            input int gie_delay, input bit pulse, input bit disturb,
                            input string tag);
        int c, exp_cyc, budget;
        bit seen, disturbed;
        mem[VEC] = vec;
        sp_in = sp; pc_resume = pc; flags_in = flg;
        hold_left = hold;
        wr_addr_q.delete(); wr_data_q.delete();
        c = cyc;
        drain_start = c + 2 + gie_delay;
        drain_len = drain;
        exp_cyc = c + 7 + gie_delay + hold + drain;
        if (pulse) begin gie = (gie_delay == 0); int_sig = 1'b1; end
        else begin gie = 1'b1; rti_done = 1'b1; end
        tick();
        int_sig = 1'b0; rti_done = 1'b0;
        for (int k = 0; k < gie_delay; k++) begin
            checks++;
            if (stall_fetch !== 1'b0) begin
                errors++;
                $display("FAIL %s_gie_blocked: stall=%b expected 0", tag, stall_fetch);
            end
            tick();
        end
        gie = 1'b1;
        seen = 0; disturbed = 0; budget = 0;
        while (!seen && budget < 40) begin
            if (pc_ld === 1'b1) seen = 1;
            else begin
                if (disturb && stall_fetch && !disturbed) begin
                    gie = 1'b0; rti_done = 1'b1; disturbed = 1;
                end
                tick();
                rti_done = 1'b0;
                budget++;
            end
        end
        checks++;
        if (!seen || cyc != exp_cyc) begin
            errors++;
            $display("FAIL %s_latency: pc_ld seen=%0d at %0d cycles, expected %0d",
                     tag, seen, cyc - c, exp_cyc - c);
        end
        checks++;
        if (pc_ld_val !== vec || sp_wr_val !== 8'(sp - 8'd2)) begin
            errors++;
            $display("FAIL %s_jump: pc_ld_val=%h sp_wr_val=%h expected %h %h",
                     tag, pc_ld_val, sp_wr_val, vec, 8'(sp - 8'd2));
        end
        checks++;
        if ({flush, sp_wr_en, stall_fetch, in_service} !== 4'b1110) begin
            errors++;
            $display("FAIL %s_jump_strobes: flush/spwe/stall/insvc=%b expected 1110",
                     tag, {flush, sp_wr_en, stall_fetch, in_service});
        end
        tick();
        checks++;
        if ({in_service, pc_ld, flush, sp_wr_en, stall_fetch, mem_req} !== 6'b100000) begin
            errors++;
            $display("FAIL %s_service: insvc/pcld/flush/spwe/stall/req=%b expected 100000",
                     tag, {in_service, pc_ld, flush, sp_wr_en, stall_fetch, mem_req});
        end
        checks++;
        if (wr_addr_q.size() != 2) begin
            errors++;
            $display("FAIL %s_push_count: got %0d expected 2", tag, wr_addr_q.size());
        end else if (wr_addr_q[0] !== sp || wr_data_q[0] !== pc ||
                     wr_addr_q[1] !== 8'(sp - 8'd1) || wr_data_q[1] !== {4'b0000, flg}) begin
            errors++;
            $display("FAIL %s_pushes: [%h]=%h [%h]=%h expected [%h]=%h [%h]=%h", tag,
                     wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1],
                     sp, pc, 8'(sp - 8'd1), {4'b0000, flg});
        end
        drain_start = -1000; drain_len = 0;
        gie = 1'b1;
    endtask

    task automatic leave_service(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            checks++;
            if (in_service !== 1'b1) begin
                errors++;
                $display("FAIL %s_hold_service: in_service=%b expected 1", tag, in_service);
            end
            tick();
        end
        rti_done = 1'b1;
        tick();
        rti_done = 1'b0;
        checks++;
        if (in_service !== 1'b0 || stall_fetch !== 1'b0) begin
            errors++;
            $display("FAIL %s_rti: in_service=%b stall=%b expected 0 0", tag, in_service, stall_fetch);
        end
    endtask

    task automatic check_quiet(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            checks++;
            if (stall_fetch !== 1'b0 || mem_req !== 1'b0 || in_service !== 1'b0) begin
                errors++;
                $display("FAIL %s_quiet: stall=%b req=%b insvc=%b expected 0 0 0",
                         tag, stall_fetch, mem_req, in_service);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; int_sig = 0; gie = 0; rti_done = 0; mem_gnt = 0; pipe_empty = 1;
        pc_resume = '0; sp_in = '0; flags_in = '0; mem_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        repeat (3) tick();
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, stall_fetch, flush, pc_ld, pc_ld_val,
             sp_wr_en, sp_wr_val, in_service} !== 39'd0) begin
            errors++;
            $display("FAIL reset_outputs: some output nonzero (req=%b stall=%b insvc=%b) expected all 0",
                     mem_req, stall_fetch, in_service);
        end
        rstn = 1'b1; gie = 1'b1;
        check_quiet(3, "post_reset");
    endtask

    task automatic test_basic();
        do_entry(8'hFF, 8'h22, 4'b0101, 8'h30, 0, 0, 0, 1, 0, "basic");
        leave_service(2, "basic");
    endtask

    task automatic test_gnt_stall();
        do_entry(8'hFF, 8'h5A, 4'b1001, 8'h44, 3, 0, 0, 1, 0, "gnt_hold");
        leave_service(1, "gnt_hold");
    endtask

    task automatic test_sp_wrap();
        do_entry(8'h00, 8'h81, 4'b1111, 8'hC7, 0, 0, 0, 1, 0, "sp_wrap");
        leave_service(1, "sp_wrap");
    endtask

    task automatic test_gie_late_and_nest();
        do_entry(8'h80, 8'h10, 4'b0011, 8'h60, 0, 0, 10, 1, 0, "gie_late");
        int_sig = 1'b1; tick(); tick(); int_sig = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (in_service !== 1'b1 || stall_fetch !== 1'b0) begin
                errors++;
                $display("FAIL nest_blocked: insvc=%b stall=%b expected 1 0", in_service, stall_fetch);
            end
            tick();
        end
        do_entry(8'h7E, 8'h33, 4'b0110, 8'h61, 0, 0, 0, 0, 0, "nest_entry");
        leave_service(1, "nest_entry");
        check_quiet(15, "no_requeue");
    endtask

    task automatic test_drain();
        do_entry(8'h20, 8'h47, 4'b1000, 8'h90, 0, 5, 0, 1, 0, "drain");
        leave_service(1, "drain");
    endtask

    task automatic test_gie_drop();
        do_entry(8'h35, 8'hA0, 4'b0100, 8'h0F, 1, 0, 0, 1, 1, "gie_drop");
        leave_service(1, "gie_drop");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            do_entry(8'($urandom), 8'($urandom), 4'($urandom), 8'($urandom),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 2)), 1, 0, "random");
            leave_service(int'($urandom_range(0, 3)), "random");
        end
    endtask

    task automatic test_reset_midflight();
        bit found;
        found = 0;
        sp_in = 8'h40; pc_resume = 8'h12; flags_in = 4'b0010; gie = 1'b1;
        wr_addr_q.delete(); wr_data_q.delete();
        int_sig = 1'b1; tick(); int_sig = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (mem_req && mem_we && mem_addr == 8'h3F) found = 1;
            else begin
                // Re-request while pushing PC: pending is set again and must
                // be wiped by the reset below.
                int_sig = (mem_req && mem_addr == 8'h40);
                tick();
                int_sig = 1'b0;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midflight_reach: PUSH_FLG seen=0 expected 1");
        end
        gnt_block = 1; rstn = 1'b0;
        tick();
        gnt_block = 0;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, stall_fetch, flush, pc_ld, pc_ld_val,
             sp_wr_en, sp_wr_val, in_service} !== 39'd0) begin
            errors++;
            $display("FAIL midflight_reset: req=%b addr=%h stall=%b expected all outputs 0",
                     mem_req, mem_addr, stall_fetch);
        end
        rstn = 1'b1;
        check_quiet(12, "midflight_pending");
        checks++;
        if (wr_addr_q.size() != 1) begin
            errors++;
            $display("FAIL midflight_writes: got %0d writes expected 1", wr_addr_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gnt_stall();
        test_sp_wrap();
        test_gie_late_and_nest();
        test_drain();
        test_gie_drop();
        test_back_to_back();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
